imem_ctrl: RTL and testbench

IMEM_CTRL -- requirements
Module: imem_ctrl

---
 rtl/imem_ctrl.sv | 136 +++++++++++++
 tb/tb_imem_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_ctrl.sv
// Instruction memory controller: arbitrates CPU fetches against host program loads.
// Fetch result 2 cycles after acceptance; loads stall the CPU and hold off fetches.
module imem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_count,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              cpu_run,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FETCH_WAIT = 2'd1,
        LOAD       = 2'd2,
        LOAD_DONE  = 2'd3
    } state_t;

    localparam int CNT_W = ADDR_W + 1;

    state_t            state;
    logic              load_pending;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  remaining;

    logic [ADDR_W-1:0] start_src;
    logic [CNT_W-1:0]  start_cnt;

    // A fresh load_start wins over a previously captured count; zero encodes a full image.
    always_comb begin
        start_src = load_start ? load_count : count_q;
        start_cnt = (start_src == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, start_src};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            load_pending <= 1'b0;
            count_q      <= '0;
            ptr          <= '0;
            remaining    <= '0;
            fetch_valid  <= 1'b0;
            fetch_instr  <= '0;
            load_done    <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            load_done   <= 1'b0;
            case (state)
                RUN: begin
                    if (load_start) begin
                        count_q <= load_count;
                    end
                    if (load_start || load_pending) begin
                        state        <= LOAD;
                        load_pending <= 1'b0;
                        ptr          <= '0;
                        remaining    <= start_cnt;
                    end else if (fetch_req) begin
                        state <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    fetch_instr <= mem_read_data;
                    fetch_valid <= 1'b1;
                    state       <= RUN;
                    if (load_start) begin
                        load_pending <= 1'b1;
                        count_q      <= load_count;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        ptr       <= ptr + ADDR_W'(1);
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state     <= LOAD_DONE;
                            load_done <= 1'b1;
                        end
                    end
                end
                LOAD_DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    always_comb begin
        mem_mode         = 1'b1;
        cpu_run          = 1'b0;
        load_ready       = 1'b0;
        fetch_ready      = 1'b0;
        mem_address      = fetch_addr;
        mem_write_data   = load_data;
        mem_write_enable = 1'b0;
        case (state)
            RUN: begin
                cpu_run     = 1'b1;
                fetch_ready = !(load_start || load_pending);
            end
            FETCH_WAIT: begin
                cpu_run = 1'b1;
            end
            LOAD: begin
                mem_mode         = 1'b0;
                load_ready       = 1'b1;
                mem_address      = ptr;
                mem_write_enable = load_valid;
            end
            default: begin
                mem_mode = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with a bench-owned synchronous instruction memory.
module tb_imem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [7:0]  load_count;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_done;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        cpu_run;
    logic        mem_mode;
    logic [7:0]  mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:255];
    int          wr_count;
    int          done_count;
    int          n_checks;
    int          n_fail;

    always #5 clk = ~clk;

    imem_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .load_start       (load_start),
        .load_count       (load_count),
        .load_valid       (load_valid),
        .load_data        (load_data),
        .load_ready       (load_ready),
        .load_done        (load_done),
        .fetch_req        (fetch_req),
        .fetch_addr       (fetch_addr),
        .fetch_ready      (fetch_ready),
        .fetch_valid      (fetch_valid),
        .fetch_instr      (fetch_instr),
        .cpu_run          (cpu_run),
        .mem_mode         (mem_mode),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    always @(posedge clk) begin
        if (mem_write_enable && !mem_mode) begin
            mem[mem_address] <= mem_write_data;
            wr_count         <= wr_count + 1;
        end
        if (mem_mode) mem_read_data <= mem[mem_address];
        if (load_done) done_count <= done_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_valid got %b want 0", fetch_valid); end
        n_checks++; if (fetch_instr !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_instr got %h want 0", fetch_instr); end
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done got %b want 0", load_done); end
        n_checks++; if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_run got %b want 1", cpu_run); end
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_ready got %b want 1", fetch_ready); end
        n_checks++; if ({mem_mode, load_ready, mem_write_enable} !== 3'b100) begin n_fail++; $display("FAIL reset_mem_ctrl got %b want 100", {mem_mode, load_ready, mem_write_enable}); end
    endtask

    task automatic test_fetch();
        fetch_addr = 8'd1;
        fetch_req  = 1'b1;
        #1;
        n_checks++; if ({fetch_ready, mem_address} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL fetch_accept got rdy=%b addr=%h want rdy=1 addr=01", fetch_ready, mem_address); end
        tick();
        fetch_req = 1'b0;
        #1;
        n_checks++; if ({fetch_valid, fetch_ready, mem_mode} !== 3'b001) begin n_fail++; $display("FAIL fetch_wait got v/r/m=%b want 001", {fetch_valid, fetch_ready, mem_mode}); end
        tick();
        n_checks++; if ({fetch_valid, fetch_instr} !== {1'b1, 32'hA500_0001}) begin n_fail++; $display("FAIL fetch_result got v=%b instr=%h want v=1 instr=a5000001", fetch_valid, fetch_instr); end
        n_checks++; if (mem_mode !== 1'b1) begin n_fail++; $display("FAIL fetch_mode got %b want 1", mem_mode); end
        tick();
        n_checks++; if ({fetch_valid, fetch_instr} !== {1'b0, 32'hA500_0001}) begin n_fail++; $display("FAIL fetch_hold got v=%b instr=%h want v=0 instr=a5000001", fetch_valid, fetch_instr); end
    endtask

    task automatic test_load3();
        int wr0 = wr_count;
        int dn0 = done_count;
        load_start = 1'b1;
        load_count = 8'd3;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'hAAAA_0000;
        #1;
        n_checks++; if ({cpu_run, load_ready, mem_mode, fetch_ready} !== 4'b0100) begin n_fail++; $display("FAIL load3_enter got run/rdy/mode/frdy=%b want 0100", {cpu_run, load_ready, mem_mode, fetch_ready}); end
        n_checks++; if ({mem_write_enable, mem_address} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL load3_wr0 got we=%b addr=%h want we=1 addr=00", mem_write_enable, mem_address); end
        tick();
        load_valid = 1'b0;
        #1;
        n_checks++; if ({mem_write_enable, cpu_run} !== 2'b00) begin n_fail++; $display("FAIL load3_gap got we/run=%b want 00", {mem_write_enable, cpu_run}); end
        tick();
        load_valid = 1'b1;
        load_data  = 32'hBBBB_0001;
        #1;
        n_checks++; if (mem_address !== 8'd1) begin n_fail++; $display("FAIL load3_wr1 got addr=%h want 01", mem_address); end
        tick();
        load_data = 32'hCCCC_0002;
        #1;
        n_checks++; if (mem_address !== 8'd2) begin n_fail++; $display("FAIL load3_wr2 got addr=%h want 02", mem_address); end
        tick();
        load_valid = 1'b0;
        #1;
        n_checks++; if ({load_done, cpu_run, mem_mode, load_ready} !== 4'b1010) begin n_fail++; $display("FAIL load3_done got done/run/mode/rdy=%b want 1010", {load_done, cpu_run, mem_mode, load_ready}); end
        tick();
        n_checks++; if ({load_done, cpu_run} !== 2'b01) begin n_fail++; $display("FAIL load3_return got done/run=%b want 01", {load_done, cpu_run}); end
        n_checks++; if ({mem[0], mem[1], mem[2]} !== {32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002}) begin n_fail++; $display("FAIL load3_contents got %h %h %h want aaaa0000 bbbb0001 cccc0002", mem[0], mem[1], mem[2]); end
        n_checks++; if ((wr_count - wr0) != 3 || (done_count - dn0) != 1) begin n_fail++; $display("FAIL load3_counts got writes=%0d done=%0d want 3 1", wr_count - wr0, done_count - dn0); end
        fetch_addr = 8'd2;
        fetch_req  = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        n_checks++; if ({fetch_valid, fetch_instr} !== {1'b1, 32'hCCCC_0002}) begin n_fail++; $display("FAIL load3_fetch got v=%b instr=%h want v=1 instr=cccc0002", fetch_valid, fetch_instr); end
    endtask

    task automatic test_load_vs_fetch();
        load_start = 1'b1;
        load_count = 8'd1;
        fetch_req  = 1'b1;
        fetch_addr = 8'd0;
        #1;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL lvf_ready got %b want 0", fetch_ready); end
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'hDDDD_0000;
        #1;
        n_checks++; if ({fetch_valid, cpu_run, load_ready} !== 3'b001) begin n_fail++; $display("FAIL lvf_load got v/run/rdy=%b want 001", {fetch_valid, cpu_run, load_ready}); end
        tick();
        load_valid = 1'b0;
        #1;
        n_checks++; if ({fetch_valid, load_done} !== 2'b01) begin n_fail++; $display("FAIL lvf_done got v/done=%b want 01", {fetch_valid, load_done}); end
        tick();
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL lvf_run_ready got %b want 1", fetch_ready); end
        tick();
        fetch_req = 1'b0;
        tick();
        n_checks++; if ({fetch_valid, fetch_instr} !== {1'b1, 32'hDDDD_0000}) begin n_fail++; $display("FAIL lvf_fetch got v=%b instr=%h want v=1 instr=dddd0000", fetch_valid, fetch_instr); end
    endtask

    task automatic test_start_in_fetch_wait();
        fetch_addr = 8'd2;
        fetch_req  = 1'b1;
        tick();
        fetch_req  = 1'b0;
        load_start = 1'b1;
        load_count = 8'd2;
        tick();
        load_start = 1'b0;
        #1;
        n_checks++; if ({fetch_valid, fetch_instr} !== {1'b1, 32'hCCCC_0002}) begin n_fail++; $display("FAIL sfw_fetch got v=%b instr=%h want v=1 instr=cccc0002", fetch_valid, fetch_instr); end
        n_checks++; if ({fetch_ready, cpu_run} !== 2'b01) begin n_fail++; $display("FAIL sfw_pending got frdy/run=%b want 01", {fetch_ready, cpu_run}); end
        tick();
        load_valid = 1'b1;
        load_data  = 32'hEEEE_0000;
        #1;
        n_checks++; if ({cpu_run, load_ready, mem_address} !== {2'b01, 8'd0}) begin n_fail++; $display("FAIL sfw_load got run/rdy=%b addr=%h want 01 00", {cpu_run, load_ready}, mem_address); end
        tick();
        load_data = 32'hFFFF_0001;
        tick();
        load_valid = 1'b0;
        #1;
        n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL sfw_done got %b want 1", load_done); end
        tick();
        n_checks++; if ({mem[0], mem[1]} !== {32'hEEEE_0000, 32'hFFFF_0001}) begin n_fail++; $display("FAIL sfw_contents got %h %h want eeee0000 ffff0001", mem[0], mem[1]); end
    endtask

    task automatic test_full_load();
        int wr0 = wr_count;
        int addr_err = 0;
        int early = 0;
        load_start = 1'b1;
        load_count = 8'd0;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h1000_0000 + i;
            #1;
            if (mem_address !== 8'(i) || !mem_write_enable) addr_err++;
            if (load_done) early++;
            tick();
        end
        load_valid = 1'b0;
        #1;
        n_checks++; if (addr_err != 0 || early != 0) begin n_fail++; $display("FAIL full_sequence got addr_err=%0d early_done=%0d want 0 0", addr_err, early); end
        n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL full_done got %b want 1", load_done); end
        n_checks++; if ((wr_count - wr0) != 256) begin n_fail++; $display("FAIL full_writes got %0d want 256", wr_count - wr0); end
        n_checks++; if ({mem[0], mem[255]} !== {32'h1000_0000, 32'h1000_00FF}) begin n_fail++; $display("FAIL full_contents got %h %h want 10000000 100000ff", mem[0], mem[255]); end
        tick();
    endtask

    task automatic test_reset_during_load();
        int dn0 = done_count;
        load_start = 1'b1;
        load_count = 8'd10;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h2000_0000 + i;
            tick();
        end
        load_valid = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if ({cpu_run, fetch_ready, mem_mode, load_ready, load_done} !== 5'b11100) begin n_fail++; $display("FAIL rdl_state got run/frdy/mode/rdy/done=%b want 11100", {cpu_run, fetch_ready, mem_mode, load_ready, load_done}); end
        n_checks++; if (done_count != dn0) begin n_fail++; $display("FAIL rdl_no_done got %0d pulses want 0", done_count - dn0); end
        n_checks++; if ({mem[0], mem[4], mem[5]} !== {32'h2000_0000, 32'h2000_0004, 32'h1000_0005}) begin n_fail++; $display("FAIL rdl_contents got %h %h %h want 20000000 20000004 10000005", mem[0], mem[4], mem[5]); end
    endtask

    task automatic test_reset_during_fetch();
        fetch_addr = 8'd3;
        fetch_req  = 1'b1;
        tick();
        fetch_req = 1'b0;
        reset     = 1'b1;
        tick();
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rdf_in_reset got %b want 0", fetch_valid); end
        reset = 1'b0;
        tick();
        n_checks++; if ({fetch_valid, fetch_instr, fetch_ready} !== {1'b0, 32'h0, 1'b1}) begin n_fail++; $display("FAIL rdf_after got v=%b instr=%h rdy=%b want 0 0 1", fetch_valid, fetch_instr, fetch_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        wr_count   = 0;
        done_count = 0;
        reset      = 1'b1;
        load_start = 1'b0;
        load_count = '0;
        load_valid = 1'b0;
        load_data  = '0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
        test_reset();
        test_fetch();
        test_load3();
        test_load_vs_fetch();
        test_start_in_fetch_wait();
        test_full_load();
        test_reset_during_load();
        test_reset_during_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
